// File: rtl/cu_pkg.sv
// cu_pkg: shared state encodings, opcode/funct fields and ALU op codes for the multicycle control unit
// No ports; imported by imm_gen and multicycle_control_unit.
package cu_pkg;
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   function automatic logic is_word_access(input logic [2:0] f3);
      return f3 == F3_W || f3 == F3_D;
   endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: instruction register to sign-extended immediate (I/S types, B type with MULTICYCLE_CU_BRANCH_EN)
// Ports: i_ir instruction register; o_imm immediate sign-extended to WORDSIZE.
module imm_gen import cu_pkg::*; #(
   parameter int WORDSIZE = 64
) (
   input  logic [31:0]         i_ir,
   output logic [WORDSIZE-1:0] o_imm
);
   logic [11:0] w_imm_i, w_imm_s;
   logic        w_unused_ir;
   assign w_imm_i     = i_ir[31:20];
   assign w_imm_s     = {i_ir[31:25], i_ir[11:7]};
   assign w_unused_ir = ^i_ir[19:12];
`ifdef MULTICYCLE_CU_BRANCH_EN
   logic [12:0] w_imm_b;
   assign w_imm_b = {i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
   assign o_imm = i_ir[6:0] == OP_BRANCH ? {{(WORDSIZE-13){w_imm_b[12]}}, w_imm_b}
                : i_ir[6:0] == OP_STORE  ? {{(WORDSIZE-12){w_imm_s[11]}}, w_imm_s}
                :                          {{(WORDSIZE-12){w_imm_i[11]}}, w_imm_i};
`else
   assign o_imm = i_ir[6:0] == OP_STORE ? {{(WORDSIZE-12){w_imm_s[11]}}, w_imm_s}
                :                         {{(WORDSIZE-12){w_imm_i[11]}}, w_imm_i};
`endif
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: instruction register plus fetch/decode/execute/memory/writeback FSM with illegal-instruction trap
// Ports: clk/reset (sync, active-high); imem_rdata/imem_valid/uc_imem_req instruction fetch handshake;
//        dm_ready/uc_dm_req/uc_dm_write_en data memory handshake; uc_rf_* register file addresses and write strobe;
//        uc_immediate sign-extended immediate; uc_mux_*_sel datapath muxes; uc_alu_operation ALU op;
//        uc_pc_write PC advance strobe; uc_illegal sticky trap flag;
//        uc_branch_taken_en beq compare strobe, present only with macro MULTICYCLE_CU_BRANCH_EN.
module multicycle_control_unit import cu_pkg::*; #(
   parameter int WORDSIZE         = 64,
   parameter int INSTRUCTION_SIZE = 32,
   parameter int MEM_TIMEOUT      = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
   input  logic                        imem_valid,
   output logic                        uc_imem_req,
   input  logic                        dm_ready,
   output logic                        uc_dm_req,
   output logic                        uc_dm_write_en,
   output logic [4:0]                  uc_rf_addr_a,
   output logic [4:0]                  uc_rf_addr_b,
   output logic [4:0]                  uc_rf_write_addr,
   output logic                        uc_rf_write_en,
   output logic [WORDSIZE-1:0]         uc_immediate,
   output logic                        uc_mux_0_sel,
   output logic                        uc_mux_1_sel,
   output logic                        uc_mux_2_sel,
   output logic [2:0]                  uc_alu_operation,
   output logic                        uc_pc_write,
   output logic                        uc_illegal
`ifdef MULTICYCLE_CU_BRANCH_EN
   ,
   output logic                        uc_branch_taken_en
`endif
);
   localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
   logic [2:0]                  r_state, w_next;
   logic [INSTRUCTION_SIZE-1:0] r_ir;
   logic [CW-1:0]               r_cnt;
   logic                        r_rst_hold;
   logic [6:0]                  w_opcode, w_f7;
   logic [2:0]                  w_f3;
   logic w_is_addi, w_is_rop, w_is_sub, w_is_load, w_is_store, w_is_beq, w_legal;
   logic w_fetch_hs, w_wait, w_timeout, w_exec_on;
   assign w_opcode   = r_ir[6:0];
   assign w_f3       = r_ir[14:12];
   assign w_f7       = r_ir[31:25];
   assign w_is_addi  = w_opcode == OP_IMM && w_f3 == F3_ADD;
   assign w_is_rop   = w_opcode == OP_REG && w_f3 == F3_ADD && (w_f7 == F7_ADD || w_f7 == F7_SUB);
   assign w_is_sub   = w_is_rop && w_f7 == F7_SUB;
   assign w_is_load  = w_opcode == OP_LOAD && is_word_access(w_f3);
   assign w_is_store = w_opcode == OP_STORE && is_word_access(w_f3);
`ifdef MULTICYCLE_CU_BRANCH_EN
   assign w_is_beq   = w_opcode == OP_BRANCH && w_f3 == F3_BEQ;
`else
   assign w_is_beq   = 1'b0;
`endif
   assign w_legal    = w_is_addi || w_is_rop || w_is_load || w_is_store || w_is_beq;
   // The cycle right after reset keeps every output low, so fetch only starts once r_rst_hold drops.
   assign w_fetch_hs = r_state == S_FETCH && !r_rst_hold && imem_valid;
   assign w_wait     = (r_state == S_FETCH && !r_rst_hold && !imem_valid) || (r_state == S_MEM && !dm_ready);
   assign w_timeout  = MEM_TIMEOUT != 0 && w_wait && r_cnt == CW'(MEM_TIMEOUT - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = w_fetch_hs ? S_DECODE : S_FETCH;
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC:   w_next = (w_is_load || w_is_store) ? S_MEM : w_is_beq ? S_FETCH : S_WB;
         S_MEM:    w_next = !dm_ready ? S_MEM : w_is_load ? S_WB : S_FETCH;
         S_WB:     w_next = S_FETCH;
         default:  w_next = S_TRAP;
      endcase
      if (w_timeout) w_next = S_TRAP;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_ir       <= '0;
         r_cnt      <= '0;
         r_rst_hold <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_rst_hold <= 1'b0;
         r_cnt      <= w_wait ? r_cnt + CW'(1) : '0;
         if (w_fetch_hs) r_ir <= imem_rdata;
      end
   end
   // ALU controls stay valid from execute through writeback so the datapath need not register them.
   assign w_exec_on        = r_state == S_EXEC || r_state == S_MEM || r_state == S_WB;
   assign uc_imem_req      = r_state == S_FETCH && !r_rst_hold;
   assign uc_dm_req        = r_state == S_MEM;
   assign uc_dm_write_en   = r_state == S_MEM && w_is_store;
   assign uc_rf_addr_a     = r_ir[19:15];
   assign uc_rf_addr_b     = r_ir[24:20];
   assign uc_rf_write_addr = r_ir[11:7];
   assign uc_rf_write_en   = r_state == S_WB;
   assign uc_mux_0_sel     = 1'b0;
   assign uc_mux_1_sel     = w_exec_on && (w_is_rop || w_is_beq);
   assign uc_mux_2_sel     = r_state == S_WB && w_is_load;
   assign uc_alu_operation = (w_exec_on && (w_is_sub || w_is_beq)) ? ALU_SUB : ALU_ADD;
   assign uc_pc_write      = r_state == S_WB || (r_state == S_MEM && w_is_store && dm_ready) || (r_state == S_EXEC && w_is_beq);
   assign uc_illegal       = r_state == S_TRAP;
`ifdef MULTICYCLE_CU_BRANCH_EN
   assign uc_branch_taken_en = r_state == S_EXEC && w_is_beq;
`endif
   imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
      .i_ir  (r_ir[31:0]),
      .o_imm (uc_immediate)
   );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for multicycle_control_unit (MEM_TIMEOUT=4)
module tb_multicycle_control_unit;
   localparam int WS = 64;
   localparam logic [10:0] IMEM = 11'b10000000000, DM = 11'b01000000000, DMW = 11'b00100000000,
                           RFW = 11'b00010000000, PCW = 11'b00001000000, ILL = 11'b00000100000,
                           M1 = 11'b00000010000, M2 = 11'b00000001000, SUB = 11'b00000000001;
   typedef struct {
      logic [10:0] v;
      logic [10:0] m;
   } exp_t;
   logic          clk = 1'b0, reset = 1'b1;
   logic [31:0]   imem_rdata = '0;
   logic          imem_valid = 1'b0, dm_ready = 1'b0;
   logic          uc_imem_req, uc_dm_req, uc_dm_write_en, uc_rf_write_en;
   logic [4:0]    uc_rf_addr_a, uc_rf_addr_b, uc_rf_write_addr;
   logic [WS-1:0] uc_immediate;
   logic          uc_mux_0_sel, uc_mux_1_sel, uc_mux_2_sel, uc_pc_write, uc_illegal;
   logic [2:0]    uc_alu_operation;
`ifdef MULTICYCLE_CU_BRANCH_EN
   logic          uc_branch_taken_en;
`endif
   int            n_checks = 0, n_errors = 0;
   exp_t          exp_q[$];
   always #5 clk = ~clk;
   multicycle_control_unit #(.WORDSIZE(WS), .INSTRUCTION_SIZE(32), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .imem_rdata(imem_rdata), .imem_valid(imem_valid), .uc_imem_req(uc_imem_req),
      .dm_ready(dm_ready), .uc_dm_req(uc_dm_req), .uc_dm_write_en(uc_dm_write_en),
      .uc_rf_addr_a(uc_rf_addr_a), .uc_rf_addr_b(uc_rf_addr_b), .uc_rf_write_addr(uc_rf_write_addr),
      .uc_rf_write_en(uc_rf_write_en), .uc_immediate(uc_immediate), .uc_mux_0_sel(uc_mux_0_sel),
      .uc_mux_1_sel(uc_mux_1_sel), .uc_mux_2_sel(uc_mux_2_sel), .uc_alu_operation(uc_alu_operation),
      .uc_pc_write(uc_pc_write), .uc_illegal(uc_illegal)
`ifdef MULTICYCLE_CU_BRANCH_EN
      , .uc_branch_taken_en(uc_branch_taken_en)
`endif
   );
   // st: 0 = strobes only, 1 = execute (ALU controls checked), 2 = writeback (mux_2 checked)
   function automatic exp_t ex(input int st, input logic [10:0] v);
      exp_t e;
      e.v = v;
      e.m = st == 1 ? 11'b11111110111 : st == 2 ? 11'b11111101000 : 11'b11111100000;
      return e;
   endfunction
   function automatic logic [10:0] obs();
      return {uc_imem_req, uc_dm_req, uc_dm_write_en, uc_rf_write_en, uc_pc_write, uc_illegal,
              uc_mux_1_sel, uc_mux_2_sel, uc_alu_operation};
   endfunction
   task automatic cycle(input logic iv, input logic dr);
      @(negedge clk);
      imem_valid = iv;
      dm_ready   = dr;
      #1;
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (obs() !== '0 || uc_immediate !== '0 || uc_rf_write_addr !== '0 || uc_rf_addr_a !== '0 || uc_mux_0_sel !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got %b imm %h rd %0d want all zero", obs(), uc_immediate, uc_rf_write_addr);
      end
      reset = 1'b0;
      cycle(1'b0, 1'b0);
      n_checks++;
      if (uc_imem_req !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_fetch imem_req got %b want 1", uc_imem_req);
      end
   endtask
   task automatic test_addi();
      logic [1:0] ins[4] = '{2'b10, 2'b00, 2'b00, 2'b00};
      exp_t e;
      imem_rdata = 32'h00500093;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0));
      exp_q.push_back(ex(1, '0));   exp_q.push_back(ex(2, RFW | PCW));
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL addi cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
         if (i == 2) begin
            n_checks++;
            if (uc_rf_write_addr !== 5'd1 || uc_rf_addr_a !== 5'd0 || uc_immediate !== 64'd5) begin
               n_errors++;
               $display("FAIL addi_fields got rd %0d rs1 %0d imm %h want rd 1 rs1 0 imm 5", uc_rf_write_addr, uc_rf_addr_a, uc_immediate);
            end
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [1:0] ins[8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
      exp_t e;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0));
      exp_q.push_back(ex(1, M1 | SUB)); exp_q.push_back(ex(2, RFW | PCW));
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0));
      exp_q.push_back(ex(1, M1)); exp_q.push_back(ex(2, RFW | PCW));
      foreach (ins[i]) begin
         imem_rdata = i < 4 ? 32'h402081B3 : 32'h002081B3;
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL b2b cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
         if (i == 2 || i == 6) begin
            n_checks++;
            if (uc_rf_write_addr !== 5'd3 || uc_rf_addr_a !== 5'd1 || uc_rf_addr_b !== 5'd2) begin
               n_errors++;
               $display("FAIL b2b_fields got rd %0d rs1 %0d rs2 %0d want 3 1 2", uc_rf_write_addr, uc_rf_addr_a, uc_rf_addr_b);
            end
         end
      end
   endtask
   task automatic test_load();
      logic [1:0] ins[7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      exp_t e;
      imem_rdata = 32'h00812283;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0)); exp_q.push_back(ex(1, '0));
      exp_q.push_back(ex(0, DM)); exp_q.push_back(ex(0, DM)); exp_q.push_back(ex(0, DM));
      exp_q.push_back(ex(2, RFW | PCW | M2));
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL load cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
         if (i == 2) begin
            n_checks++;
            if (uc_rf_write_addr !== 5'd5 || uc_rf_addr_a !== 5'd2 || uc_immediate !== 64'd8) begin
               n_errors++;
               $display("FAIL load_fields got rd %0d rs1 %0d imm %h want 5 2 8", uc_rf_write_addr, uc_rf_addr_a, uc_immediate);
            end
         end
      end
   endtask
   task automatic test_store();
      logic [1:0] ins[6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      exp_t e;
      imem_rdata = 32'hFE512E23;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0)); exp_q.push_back(ex(1, '0));
      exp_q.push_back(ex(0, DM | DMW)); exp_q.push_back(ex(0, DM | DMW | PCW)); exp_q.push_back(ex(0, IMEM));
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL store cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
         if (i == 2) begin
            n_checks++;
            if (uc_immediate !== 64'hFFFF_FFFF_FFFF_FFFC || uc_rf_addr_a !== 5'd2 || uc_rf_addr_b !== 5'd5) begin
               n_errors++;
               $display("FAIL store_fields got imm %h rs1 %0d rs2 %0d want fffffffffffffffc 2 5", uc_immediate, uc_rf_addr_a, uc_rf_addr_b);
            end
         end
      end
   endtask
   task automatic test_branch();
      logic [1:0] ins[3] = '{2'b10, 2'b00, 2'b00};
      exp_t e;
      imem_rdata = 32'h00208463;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0));
`ifdef MULTICYCLE_CU_BRANCH_EN
      exp_q.push_back(ex(1, PCW | M1 | SUB));
`else
      exp_q.push_back(ex(0, ILL));
`endif
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL beq cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
`ifdef MULTICYCLE_CU_BRANCH_EN
         n_checks++;
         if (uc_branch_taken_en !== (i == 2) || (i == 2 && uc_immediate !== 64'd8)) begin
            n_errors++;
            $display("FAIL beq_taken_en cyc%0d got %b imm %h want %b imm 8", i, uc_branch_taken_en, uc_immediate, i == 2);
         end
`endif
      end
`ifndef MULTICYCLE_CU_BRANCH_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`endif
   endtask
   task automatic test_trap();
      logic [1:0] ins[5] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
      exp_t e;
      imem_rdata = 32'h0000006F;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0));
      exp_q.push_back(ex(0, ILL)); exp_q.push_back(ex(0, ILL)); exp_q.push_back(ex(0, ILL));
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL trap cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (uc_illegal !== 1'b0 || uc_imem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL trap_reset got illegal %b imem_req %b want 0 0", uc_illegal, uc_imem_req);
      end
      reset = 1'b0;
      cycle(1'b0, 1'b0);
      n_checks++;
      if (uc_imem_req !== 1'b1 || uc_illegal !== 1'b0) begin
         n_errors++;
         $display("FAIL trap_resume got imem_req %b illegal %b want 1 0", uc_imem_req, uc_illegal);
      end
   endtask
   task automatic test_reset_mid_mem();
      logic [1:0] ins[4] = '{2'b10, 2'b00, 2'b00, 2'b00};
      exp_t e;
      imem_rdata = 32'h00812283;
      exp_q.push_back(ex(0, IMEM)); exp_q.push_back(ex(0, '0)); exp_q.push_back(ex(1, '0)); exp_q.push_back(ex(0, DM));
      foreach (ins[i]) begin
         cycle(ins[i][1], ins[i][0]);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL rst_mem cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (uc_dm_req !== 1'b0 || uc_imem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mem_drop got dm_req %b imem_req %b want 0 0", uc_dm_req, uc_imem_req);
      end
      reset = 1'b0;
      cycle(1'b0, 1'b0);
      n_checks++;
      if (uc_imem_req !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mem_resume imem_req got %b want 1", uc_imem_req);
      end
   endtask
   task automatic test_timeout();
      exp_t e;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) exp_q.push_back(ex(0, IMEM));
      repeat (2) exp_q.push_back(ex(0, ILL));
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            n_errors++;
            $display("FAIL timeout cyc%0d got %b want %b", i, obs() & e.m, e.v & e.m);
         end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_load();
      test_store();
      test_branch();
      test_trap();
      test_reset_mid_mem();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
